// File: rtl/sipo_frame_ctrl_pkg.sv
// Shared definitions for the SIPO frame controller: FSM state encodings and
// the serial bit order used by the shift register.
package sipo_frame_ctrl_pkg;

  // Controller states; ST_PARITY is only reachable when PARITY_CHECK_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  // Frames arrive LSB first: the first serial bit ends up in q[0].
  localparam bit LSB_FIRST = 1'b1;

endpackage

// File: rtl/sipo_frame_ctrl_shreg.sv
// sipo_shreg: WIDTH-bit serial-in/parallel-out shift register with a shift
// enable and asynchronous active-low reset. Bit order comes from the package.
module sipo_shreg
  import sipo_frame_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             shift_en,
  input  logic             data_in,
  output logic [WIDTH-1:0] q
);

  generate
    if (LSB_FIRST) begin : g_lsb_first
      // Shift right so that the oldest bit settles in q[0] after WIDTH shifts.
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       q <= '0;
        else if (shift_en) q <= {data_in, q[WIDTH-1:1]};
      end
    end else begin : g_msb_first
      // Shift left so that the oldest bit settles in q[WIDTH-1].
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)       q <= '0;
        else if (shift_en) q <= {q[WIDTH-2:0], data_in};
      end
    end
  endgenerate

endmodule

// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: sequences capture of one WIDTH-bit serial frame after a
// start pulse and presents it on data_out with a valid/ready handshake.
// Optional feature macro: PARITY_CHECK_EN adds a trailing parity bit state
// and the par_err output.
//
// Handshake: a word transfers on any rising edge where valid=1 and ready=1.
// valid stays high until that transfer; ready with valid=0 is ignored. A frame
// completing while valid=1 and ready=0 is dropped and sets the sticky overrun
// flag, which clears on the next transfer that is not also a completion.
module sipo_frame_ctrl
  import sipo_frame_ctrl_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             data_in,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  output logic             busy,
  output logic             overrun,
`ifdef PARITY_CHECK_EN
  output logic             par_err,
`endif
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  generate
    if (WIDTH < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
      $error("sipo_frame_ctrl: WIDTH must be >= 2 and PARITY_ODD 0 or 1");
    end
  endgenerate

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            shift_en;
  logic            last_bit;
  logic            complete;
  logic [WIDTH-1:0] word;

  // Bits are sampled on the start edge in IDLE and on every SHIFT edge.
  assign shift_en = ((state == ST_IDLE) && start) || (state == ST_SHIFT);
  assign last_bit = (state == ST_SHIFT) && (cnt == LAST_CNT);
  assign busy     = (state != ST_IDLE);
  assign state_dbg = state;

`ifdef PARITY_CHECK_EN
  logic par_calc;
  // With parity, the word is already complete in q; data_in carries the parity bit.
  assign complete = (state == ST_PARITY);
  assign word     = q;
  assign par_calc = ((^q) ^ data_in) != 1'(PARITY_ODD);
`else
  // Without parity, the completed word is the shift-register value after this edge.
  assign complete = last_bit;
  assign word     = {data_in, q[WIDTH-1:1]};
`endif

  sipo_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk      (clk),
    .resetn   (resetn),
    .shift_en (shift_en),
    .data_in  (data_in),
    .q        (q)
  );

  // Frame sequencing FSM and bit counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            cnt   <= CW'(1);
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (last_bit) begin
            cnt <= '0;
`ifdef PARITY_CHECK_EN
            state <= ST_PARITY;
`else
            state <= ST_IDLE;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_PARITY: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Output word, valid/overrun handshake flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_out <= '0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
    end else if (complete) begin
      if (!valid || ready) begin
        data_out <= word;
        valid    <= 1'b1;
      end else begin
        overrun  <= 1'b1;
      end
    end else if (valid && ready) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

`ifdef PARITY_CHECK_EN
  // Parity error travels with data_out: loaded with it, cleared on transfer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      par_err <= 1'b0;
    end else if (complete) begin
      if (!valid || ready) par_err <= par_calc;
    end else if (valid && ready) begin
      par_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Testbench for sipo_frame_ctrl (WIDTH=4, PARITY_ODD=0). Directed frames with
// hand-computed words; accepted words go into exp_q and a negedge monitor
// compares data_out on every valid/ready transfer.
module tb_sipo_frame_ctrl;
  localparam int W = 4;

`ifdef PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         resetn;
  logic         start;
  logic         data_in;
  logic         ready;
  logic [W-1:0] q;
  logic [W-1:0] data_out;
  logic         valid;
  logic         busy;
  logic         overrun;
  logic [1:0]   state_dbg;
`ifdef PARITY_CHECK_EN
  logic         par_err;
`endif

  always #5 clk = ~clk;

  sipo_frame_ctrl #(.WIDTH(W), .PARITY_ODD(0)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .data_in   (data_in),
    .ready     (ready),
    .q         (q),
    .data_out  (data_out),
    .valid     (valid),
    .busy      (busy),
    .overrun   (overrun),
`ifdef PARITY_CHECK_EN
    .par_err   (par_err),
`endif
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every transfer must match the oldest expected word.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (resetn === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: data_out=%0h transferred with nothing expected", data_out);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard_data_out", 32'(data_out), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends w LSB first (plus pbit when parity is enabled). ready_last raises
  // ready only on the completion edge. push records w as an accepted word.
  task automatic send_frame(input logic [W-1:0] w, input logic pbit,
                            input logic ready_last, input logic push);
    for (int i = 0; i < W; i++) begin
      start   = (i == 0);
      data_in = w[i];
      if (i == W - 1 && ready_last && !PAR) ready = 1'b1;
      tick();
      start = 1'b0;
      if (i < W - 1) check("busy_mid_frame", 32'(busy), 32'd1);
    end
    data_in = pbit;
    if (PAR) begin
      check("busy_before_parity", 32'(busy), 32'd1);
      if (ready_last) ready = 1'b1;
      tick();
    end
    if (ready_last) ready = 1'b0;
    check("busy_after_frame", 32'(busy), 32'd0);
    check("q_after_frame", 32'(q), 32'(w));
    if (push) exp_q.push_back(w);
  endtask

  task automatic handshake();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("valid_after_handshake", 32'(valid), 32'd0);
    check("overrun_after_handshake", 32'(overrun), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    resetn  = 1'b0;
    start   = 1'b0;
    data_in = 1'b0;
    ready   = 1'b0;
    tick();
    tick();
    // Reset state
    check("rst_q", 32'(q), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    resetn = 1'b1;
    tick();

    // Basic capture: bits 1,0,1,1 -> 4'b1101
    send_frame(4'b1101, 1'b1, 1'b0, 1'b1);
    check("t2_valid", 32'(valid), 32'd1);
    check("t2_data_out", 32'(data_out), 32'hd);

    // Overrun: ready held low, bits 1,1,0,0 dropped
    send_frame(4'b0011, 1'b0, 1'b0, 1'b0);
    check("t3_overrun", 32'(overrun), 32'd1);
    check("t3_valid", 32'(valid), 32'd1);
    check("t3_data_out_held", 32'(data_out), 32'hd);
    tick();
    check("t3_overrun_sticky", 32'(overrun), 32'd1);
    handshake();

    // Transfer coinciding with completion: bits 0,1,0,0 -> 4'b0010
    send_frame(4'b0110, 1'b0, 1'b0, 1'b1);
    check("t4_state_idle", 32'(state_dbg), 32'd0);
    send_frame(4'b0010, 1'b1, 1'b1, 1'b1);
    check("t4_valid_stays", 32'(valid), 32'd1);
    check("t4_data_out", 32'(data_out), 32'h2);
    check("t4_no_overrun", 32'(overrun), 32'd0);
    handshake();

    // Reset mid-frame with a word pending
    send_frame(4'b0101, 1'b0, 1'b0, 1'b1);
    start = 1'b1; data_in = 1'b1;
    tick();
    start = 1'b0; data_in = 1'b0;
    check("t5_state_shift", 32'(state_dbg), 32'd1);
    tick();
    check("t5_busy_before_reset", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    exp_q.delete();
    check("t5_q", 32'(q), 32'd0);
    check("t5_data_out", 32'(data_out), 32'd0);
    check("t5_valid", 32'(valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_overrun", 32'(overrun), 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    send_frame(4'b1000, 1'b1, 1'b0, 1'b1);
    check("t5_data_out_after", 32'(data_out), 32'h8);
    handshake();

    // Back-to-back frames with ready held high
    ready = 1'b1;
    send_frame(4'b1001, 1'b0, 1'b0, 1'b1);
    send_frame(4'b0111, 1'b1, 1'b0, 1'b1);
    tick();
    ready = 1'b0;
    check("b2b_valid_cleared", 32'(valid), 32'd0);
    check("b2b_overrun", 32'(overrun), 32'd0);

`ifdef PARITY_CHECK_EN
    // Parity: 1101 has odd weight, so pbit 0 is an even-parity error
    send_frame(4'b1101, 1'b0, 1'b0, 1'b1);
    check("par_err_set", 32'(par_err), 32'd1);
    check("par_data_out", 32'(data_out), 32'hd);
    handshake();
    check("par_err_cleared", 32'(par_err), 32'd0);
    send_frame(4'b1101, 1'b1, 1'b0, 1'b1);
    check("par_err_clear_good", 32'(par_err), 32'd0);
    check("par_valid", 32'(valid), 32'd1);
    handshake();
`endif

    tick();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
